mux_n1_rr_reg: RTL and testbench

//  Parametrised N:1 channel multiplexer with a registered output stage and valid/ready

---
 rtl/mux_n1_rr_reg_if.sv | 28 ++
 rtl/mux_n1_rr_reg.sv | 105 ++++++++++
 tb/tb_mux_n1_rr_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mux_n1_rr_reg_if.sv
// Handshake bundle for the N:1 round-robin / fixed-select multiplexer.
// The slave modport is the multiplexer itself. The master modport is whatever
// drives the channels and sinks the output, such as a testbench or a wrapper.
interface mux_n1_rr_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic                   mode;     // 0 = fixed select, 1 = round-robin
  logic [SELW-1:0]        s;        // fixed-select channel index
  logic [NCH*WIDTH-1:0]   i;        // packed channel data, channel k at [k*WIDTH +: WIDTH]
  logic [NCH-1:0]         i_valid;
  logic [NCH-1:0]         i_ready;
  logic [WIDTH-1:0]       o;
  logic                   o_valid;
  logic                   o_ready;
  logic [SELW-1:0]        o_ch;

  modport slave (
    input  mode, s, i, i_valid, o_ready,
    output i_ready, o, o_valid, o_ch
  );

  modport master (
    output mode, s, i, i_valid, o_ready,
    input  i_ready, o, o_valid, o_ch
  );
endinterface

// File: rtl/mux_n1_rr_reg.sv
// N:1 channel multiplexer with a single registered output stage.
// The grant comes from a fixed select (mode=0) or from a round-robin scan that
// starts at an internal pointer (mode=1). Per-channel ready is combinational.
// There is no skid buffer: an input can load only when the output register is
// empty or is being drained in the same cycle.
module mux_n1_rr_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  mux_n1_rr_reg_if.slave      bus
);

  // Output register and round-robin pointer
  logic [WIDTH-1:0] r_o;
  logic             r_o_valid;
  logic [SELW-1:0]  r_o_ch;
  logic [SELW-1:0]  r_ptr;

  // Grant and handshake decode
  logic             w_load_en;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_next;
  logic [WIDTH-1:0] w_data [NCH];

  // Channel index reached after stepping j places forward from p, modulo NCH.
  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] p, input int j);
    int sum;
    sum = int'(p) + j;
    if (sum >= NCH) begin
      sum = sum - NCH;
    end
    return SELW'(sum);
  endfunction

  // Unpack channel data and drive the per-channel ready bits.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_data[gi]      = bus.i[gi*WIDTH +: WIDTH];
      assign bus.i_ready[gi] = !rst && w_gnt_vld && (w_gnt == SELW'(gi)) && w_load_en;
    end
  endgenerate

  // The register can take a new word when it is empty or being drained.
  assign w_load_en = !r_o_valid || bus.o_ready;

  // Grant selection. In round-robin mode the scan runs from the highest offset
  // down to offset 0, so the last match written is the one nearest the pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (!bus.mode) begin
      if (int'(bus.s) < NCH) begin
        w_gnt_vld = 1'b1;
        w_gnt     = bus.s;
      end
    end else begin
      for (int j = NCH - 1; j >= 0; j--) begin
        if (bus.i_valid[rr_idx(r_ptr, j)]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = rr_idx(r_ptr, j);
        end
      end
    end
  end

  // A transfer happens only on the granted channel, and only when that channel is valid and the register can load.
  assign w_xfer     = !rst && w_gnt_vld && bus.i_valid[w_gnt] && w_load_en;
  assign w_ptr_next = (w_gnt == SELW'(NCH - 1)) ? '0 : w_gnt + 1'b1;

  // Output register: load on transfer, empty on an idle load slot, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_o_ch    <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_o       <= w_data[w_gnt];
        r_o_ch    <= w_gnt;
        r_o_valid <= 1'b1;
      end else begin
        r_o_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: moves past the winner only on round-robin transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer && bus.mode) begin
      r_ptr <= w_ptr_next;
    end
  end

  assign bus.o       = r_o;
  assign bus.o_valid = r_o_valid;
  assign bus.o_ch    = r_o_ch;

endmodule

// File: tb/tb_mux_n1_rr_reg.sv
// Self-checking bench for mux_n1_rr_reg: directed scenarios, then random traffic.
// A transaction-level model of the output register and pointer is kept here.
module tb_mux_n1_rr_reg;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_n1_rr_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

  mux_n1_rr_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference model state
  logic [WIDTH-1:0] m_o;
  logic             m_v;
  int               m_ch;
  int               m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winning channel under the spec rules, or -1 when nothing is granted.
  function automatic int model_grant(input logic md, input logic [SELW-1:0] sel,
                                     input logic [NCH-1:0] v, input int ptr);
    if (!md) return (int'(sel) < NCH) ? int'(sel) : -1;
    for (int off = 0; off < NCH; off++) begin
      if (v[(ptr + off) % NCH]) return (ptr + off) % NCH;
    end
    return -1;
  endfunction

  // One clock of stimulus, starting and ending just after a falling edge.
  task automatic step(input logic r, input logic md, input logic [SELW-1:0] sel,
                      input logic [NCH*WIDTH-1:0] d, input logic [NCH-1:0] v,
                      input logic ordy);
    int g;
    logic ld;
    logic [NCH-1:0] exp_rdy;
    rst = r;
    bus.mode = md;
    bus.s = sel;
    bus.i = d;
    bus.i_valid = v;
    bus.o_ready = ordy;
    #1;
    g  = model_grant(md, sel, v, m_ptr);
    ld = !m_v || ordy;
    exp_rdy = '0;
    if (!r && g >= 0 && ld) exp_rdy[g] = 1'b1;
    check("i_ready", 32'(bus.i_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_o = '0; m_v = 1'b0; m_ch = 0; m_ptr = 0;
    end else if (ld) begin
      if (g >= 0 && v[g]) begin
        m_o  = d[g*WIDTH +: WIDTH];
        m_ch = g;
        m_v  = 1'b1;
        if (md) m_ptr = (g + 1) % NCH;
      end else begin
        m_v = 1'b0;
      end
    end
    @(negedge clk);
    check("o", 32'(bus.o), 32'(m_o));
    check("o_valid", 32'(bus.o_valid), 32'(m_v));
    check("o_ch", 32'(bus.o_ch), 32'(m_ch));
    step_no++;
    $display("step %0d rst=%0b mode=%0b s=%0d v=%b ordy=%b rdy=%b -> o=%h ov=%0b och=%0d",
             step_no, r, md, sel, v, ordy, exp_rdy, bus.o, bus.o_valid, bus.o_ch);
  endtask

  logic [NCH*WIDTH-1:0] d_inc;
  logic [NCH*WIDTH-1:0] d_rnd;
  int seq4 [6] = '{0, 1, 2, 3, 0, 1};
  int seq5 [4] = '{3, 1, 3, 1};

  initial begin
    m_o = '0; m_v = 1'b0; m_ch = 0; m_ptr = 0;
    rst = 1'b1;
    bus.mode = 1'b0; bus.s = '0; bus.i = '0; bus.i_valid = '0; bus.o_ready = 1'b0;
    for (int k = 0; k < NCH; k++) d_inc[k*WIDTH +: WIDTH] = WIDTH'(8'h10 + k);
    @(negedge clk);

    // Power-on reset
    step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);

    // Fixed select on channel 2
    step(1'b0, 1'b0, 2'd2, {8'h44, 8'hA5, 8'h22, 8'h11}, 4'b1111, 1'b1);
    check("fix_o", 32'(bus.o), 32'hA5);
    check("fix_och", 32'(bus.o_ch), 32'd2);
    check("fix_ov", 32'(bus.o_valid), 32'd1);

    // Backpressure: held word, then ch1 loads with no bubble
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 2'd1, {8'h44, 8'h33, 8'h3C, 8'h11}, 4'b0010, 1'b0);
      check("bp_hold_o", 32'(bus.o), 32'hA5);
      check("bp_hold_rdy", 32'(bus.i_ready), 32'd0);
    end
    step(1'b0, 1'b0, 2'd1, {8'h44, 8'h33, 8'h3C, 8'h11}, 4'b0010, 1'b1);
    check("bp_load_o", 32'(bus.o), 32'h3C);
    check("bp_load_och", 32'(bus.o_ch), 32'd1);

    // Reset mid-stream with a valid word held
    step(1'b0, 1'b0, 2'd1, {8'h44, 8'h33, 8'h77, 8'h11}, 4'b0010, 1'b0);
    step(1'b1, 1'b0, 2'd1, {8'h44, 8'h33, 8'h77, 8'h11}, 4'b0010, 1'b0);
    check("rst_rdy", 32'(bus.i_ready), 32'd0);
    step(1'b1, 1'b0, 2'd1, {8'h44, 8'h33, 8'h77, 8'h11}, 4'b0010, 1'b0);
    check("rst2_o", 32'(bus.o), 32'd0);
    check("rst2_ov", 32'(bus.o_valid), 32'd0);
    check("rst2_och", 32'(bus.o_ch), 32'd0);

    // Round-robin fairness, all channels valid
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, 2'd0, d_inc, 4'b1111, 1'b1);
      check("rr_och", 32'(bus.o_ch), 32'(seq4[c]));
      check("rr_ov", 32'(bus.o_valid), 32'd1);
    end

    // Advance the pointer to 3, then only ch1/ch3 valid
    step(1'b0, 1'b1, 2'd0, d_inc, 4'b0100, 1'b1);
    check("skip_setup_och", 32'(bus.o_ch), 32'd2);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, 2'd0, d_inc, 4'b1010, 1'b1);
      check("skip_och", 32'(bus.o_ch), 32'(seq5[c]));
    end
    step(1'b0, 1'b1, 2'd0, d_inc, 4'b0000, 1'b1);
    check("drain_ov", 32'(bus.o_valid), 32'd0);
    check("drain_och_hold", 32'(bus.o_ch), 32'd1);
    step(1'b0, 1'b1, 2'd0, d_inc, 4'b0000, 1'b1);

    // Mode switch while the sink stalls
    step(1'b0, 1'b1, 2'd0, d_inc, 4'b1111, 1'b0);
    check("msw_load_och", 32'(bus.o_ch), 32'd2);
    step(1'b0, 1'b0, 2'd0, d_inc, 4'b1111, 1'b0);
    check("msw_hold_och", 32'(bus.o_ch), 32'd2);
    check("msw_hold_o", 32'(bus.o), 32'h12);
    step(1'b0, 1'b0, 2'd0, d_inc, 4'b1111, 1'b1);
    check("msw_fix_och", 32'(bus.o_ch), 32'd0);
    step(1'b0, 1'b1, 2'd0, d_inc, 4'b1111, 1'b1);
    check("msw_ptr_kept", 32'(bus.o_ch), 32'd3);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NCH; k++) d_rnd[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      step(($urandom_range(0, 39) == 0), 1'($urandom), SELW'($urandom),
           d_rnd, NCH'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
